// File: rtl/control_fsm.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback steps.
// Latency: Moore outputs follow state_q; instructions take 3-5 cycles plus memory stalls.
// Backpressure: memory states hold while mem_ready=0; a run of stalls at the limit ends in FAULT.
module control_fsm #(
  parameter int STALL_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       adr_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic       instr_retired,
  output logic       illegal_instr,
  output logic       mem_fault,
  output logic [3:0] state_dbg
);

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_BTYPE  = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // ALU decoder operation classes
  localparam logic [1:0] ALU_OP__ADD                = 2'b00;
  localparam logic [1:0] ALU_OP__BRANCH             = 2'b01;
  localparam logic [1:0] ALU_OP__REGISTER_OPERATION = 2'b10;

  // Stall counter only ever holds values 0..STALL_LIMIT-1 before FAULT is taken.
  localparam int CW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
  localparam logic [CW-1:0] LIMIT_M1 = CW'(STALL_LIMIT - 1);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LINK     = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_FAULT    = 4'd15
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] stall_q, stall_d;

  // State and stall-counter registers with synchronous reset back to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  // Next-state logic; stall counter is zero unless a memory state is waiting on mem_ready.
  always_comb begin
    state_d = state_q;
    stall_d = '0;
    case (state_q)
      S_FETCH, S_MEMREAD, S_MEMWRITE: begin
        if (mem_ready) begin
          case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_MEMREAD: state_d = S_MEMWB;
            default:   state_d = S_FETCH;
          endcase
        end else if ((STALL_LIMIT != 0) && (stall_q == LIMIT_M1)) begin
          state_d = S_FAULT;
        end else begin
          stall_d = stall_q + CW'(1);
        end
      end
      S_DECODE: begin
        case (opcode)
          OPC_LOAD, OPC_STORE: state_d = S_MEMADR;
          OPC_RTYPE:           state_d = S_EXECUTER;
          OPC_ITYPE:           state_d = S_EXECUTEI;
          OPC_BTYPE:           state_d = S_BRANCH;
          OPC_JAL:             state_d = S_JAL;
          OPC_JALR:            state_d = S_JALR;
          OPC_LUI:             state_d = S_LUI;
          OPC_AUIPC:           state_d = S_AUIPC;
          default:             state_d = S_FETCH;
        endcase
      end
      // opcode is still the instruction register contents, so load/store is re-checked here.
      S_MEMADR:   state_d = (opcode == OPC_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMWB:    state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR:     state_d = S_LINK;
      S_LINK:     state_d = S_FETCH;
      S_LUI:      state_d = S_ALUWB;
      S_AUIPC:    state_d = S_ALUWB;
      S_FAULT:    state_d = S_FAULT;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore outputs per state; only FETCH/MEMWRITE/BRANCH look at mem_ready/branch_taken. Reset forces all to 0.
  always_comb begin
    mem_req       = 1'b0;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    result_src    = 2'b00;
    alu_op        = ALU_OP__ADD;
    instr_retired = 1'b0;
    illegal_instr = 1'b0;
    mem_fault     = 1'b0;
    state_dbg     = 4'd0;
    if (!reset) begin
      state_dbg = state_q;
      case (state_q)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          case (opcode)
            OPC_LOAD, OPC_STORE, OPC_RTYPE, OPC_ITYPE, OPC_BTYPE,
            OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: illegal_instr = 1'b0;
            default:                               illegal_instr = 1'b1;
          endcase
        end
        S_MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEMWB: begin
          result_src    = 2'b01;
          reg_write     = 1'b1;
          instr_retired = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req       = 1'b1;
          adr_src       = 1'b1;
          mem_write     = 1'b1;
          instr_retired = mem_ready;
        end
        S_EXECUTER: begin
          alu_src_a = 2'b10;
          alu_op    = ALU_OP__REGISTER_OPERATION;
        end
        S_EXECUTEI: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          alu_op    = ALU_OP__REGISTER_OPERATION;
        end
        S_ALUWB: begin
          reg_write     = 1'b1;
          instr_retired = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 2'b10;
          alu_op        = ALU_OP__BRANCH;
          pc_write      = branch_taken;
          instr_retired = 1'b1;
        end
        S_JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
        end
        S_JALR: begin
          alu_src_a  = 2'b10;
          alu_src_b  = 2'b01;
          result_src = 2'b10;
          pc_write   = 1'b1;
        end
        S_LINK: begin
          alu_src_a     = 2'b01;
          alu_src_b     = 2'b10;
          result_src    = 2'b10;
          reg_write     = 1'b1;
          instr_retired = 1'b1;
        end
        S_LUI: begin
          alu_src_a = 2'b11;
          alu_src_b = 2'b01;
        end
        S_AUIPC: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
        end
        S_FAULT: begin
          mem_fault = 1'b1;
        end
        default: begin
          mem_fault = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: directed per-cycle vectors with hand-computed expected outputs.
// Stimulus pushes the expected output word for each cycle; a monitor pops and compares at negedge.
// No backpressure: the DUT presents a full output word every cycle.
module tb_control_fsm;

  logic       clk;
  logic       reset;
  logic [6:0] opcode;
  logic       branch_taken;
  logic       mem_ready;
  logic       mem_req, pc_write, ir_write, reg_write, mem_write, adr_src;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
  logic       instr_retired, illegal_instr, mem_fault;
  logic [3:0] state_dbg;

  control_fsm #(.STALL_LIMIT(15)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .pc_write(pc_write),
    .ir_write(ir_write), .reg_write(reg_write), .mem_write(mem_write),
    .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .alu_op(alu_op), .instr_retired(instr_retired),
    .illegal_instr(illegal_instr), .mem_fault(mem_fault), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       mreq;
    logic       adr;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] rs;
    logic [1:0] op;
    logic       pcw;
    logic       irw;
    logic       rw;
    logic       mw;
    logic       ret;
    logic       ill;
    logic       flt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  // State encodings as seen on state_dbg
  localparam int F = 0, D = 1, MA = 2, MRD = 3, MWB = 4, MWR = 5, ER = 6, EI = 7;
  localparam int AWB = 8, BR = 9, JL = 10, JR = 11, LK = 12, LU = 13, AU = 14, FL = 15;

  // One cycle: drive inputs just after the edge and queue the output word expected for that cycle.
  task automatic cyc(input string nm, input int rst, input int opc, input int mr, input int bt,
                     input int st, input int mreq, input int adr, input int a, input int b,
                     input int rs, input int op, input int pcw, input int irw, input int rw,
                     input int mw, input int ret, input int ill, input int flt);
    exp_t e;
    @(posedge clk);
    #1;
    reset        = 1'(rst);
    opcode       = 7'(opc);
    mem_ready    = 1'(mr);
    branch_taken = 1'(bt);
    e.st = 4'(st);  e.mreq = 1'(mreq); e.adr = 1'(adr);
    e.a  = 2'(a);   e.b    = 2'(b);    e.rs  = 2'(rs);  e.op = 2'(op);
    e.pcw = 1'(pcw); e.irw = 1'(irw);  e.rw  = 1'(rw);  e.mw = 1'(mw);
    e.ret = 1'(ret); e.ill = 1'(ill);  e.flt = 1'(flt);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Shorthands for common cycles
  task automatic fetch_ok(input string nm);
    cyc(nm, 0, 0, 1, 0,  F, 1, 0, 0, 2, 2, 0,  1, 1, 0, 0, 0, 0, 0);
  endtask
  task automatic decode(input string nm, input int opc, input int ill);
    cyc(nm, 0, opc, 1, 0,  D, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, ill, 0);
  endtask
  task automatic aluwb(input string nm);
    cyc(nm, 0, 0, 1, 0,  AWB, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 0);
  endtask

  // Monitor: the DUT presents outputs every cycle, so pop whenever an expectation is queued.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  g;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      g.st = state_dbg; g.mreq = mem_req; g.adr = adr_src;
      g.a = alu_src_a; g.b = alu_src_b; g.rs = result_src; g.op = alu_op;
      g.pcw = pc_write; g.irw = ir_write; g.rw = reg_write; g.mw = mem_write;
      g.ret = instr_retired; g.ill = illegal_instr; g.flt = mem_fault;
      n_chk++;
      if (g === e) n_pass++;
      else $display("FAIL %s: got %h required %h", nm, g, e);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; opcode = '0; mem_ready = 1'b1; branch_taken = 1'b1;

    // Reset held: everything 0 even with mem_ready/branch_taken high
    cyc("rst0", 1, 'h33, 1, 1,  0, 0,0,0,0,0,0, 0,0,0,0,0,0,0);
    cyc("rst1", 1, 'h33, 1, 1,  0, 0,0,0,0,0,0, 0,0,0,0,0,0,0);
    // First cycle after release: FETCH with mem_req, memory not yet ready
    cyc("rel_fetch", 0, 0, 0, 0,  F, 1, 0, 0, 2, 2, 0,  0, 0, 0, 0, 0, 0, 0);

    // R-type, mem_ready always 1
    fetch_ok("r_fetch");
    decode("r_dec", 'h33, 0);
    cyc("r_exec", 0, 'h33, 1, 0,  ER, 0, 0, 2, 0, 0, 2,  0, 0, 0, 0, 0, 0, 0);
    aluwb("r_wb");

    // Load with three stalled cycles in MEMREAD
    fetch_ok("ld_fetch");
    decode("ld_dec", 'h03, 0);
    cyc("ld_adr",   0, 'h03, 1, 0,  MA,  0, 0, 2, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    cyc("ld_rd0",   0, 'h03, 0, 0,  MRD, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    cyc("ld_rd1",   0, 'h03, 0, 0,  MRD, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    cyc("ld_rd2",   0, 'h03, 0, 0,  MRD, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    cyc("ld_rd3",   0, 'h03, 1, 0,  MRD, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    cyc("ld_wb",    0, 'h03, 0, 0,  MWB, 0, 0, 0, 0, 1, 0,  0, 0, 1, 0, 1, 0, 0);

    // Branch not taken then taken
    fetch_ok("bn_fetch");
    decode("bn_dec", 'h63, 0);
    cyc("bn_br", 0, 'h63, 1, 0,  BR, 0, 0, 2, 0, 0, 1,  0, 0, 0, 0, 1, 0, 0);
    fetch_ok("bt_fetch");
    decode("bt_dec", 'h63, 0);
    cyc("bt_br", 0, 'h63, 0, 1,  BR, 0, 0, 2, 0, 0, 1,  1, 0, 0, 0, 1, 0, 0);

    // JALR then LINK
    fetch_ok("jr_fetch");
    decode("jr_dec", 'h67, 0);
    cyc("jr_jalr", 0, 'h67, 1, 0,  JR, 0, 0, 2, 1, 2, 0,  1, 0, 0, 0, 0, 0, 0);
    cyc("jr_link", 0, 'h67, 1, 0,  LK, 0, 0, 1, 2, 2, 0,  0, 0, 1, 0, 1, 0, 0);

    // Illegal opcode 0x7F
    fetch_ok("il_fetch");
    decode("il_dec", 'h7F, 1);

    // Store with one stall in MEMWRITE
    fetch_ok("st_fetch");
    decode("st_dec", 'h23, 0);
    cyc("st_adr", 0, 'h23, 1, 0,  MA,  0, 0, 2, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    cyc("st_w0",  0, 'h23, 0, 0,  MWR, 1, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0);
    cyc("st_w1",  0, 'h23, 1, 0,  MWR, 1, 1, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0, 0);

    // JAL, LUI, AUIPC, I-type
    fetch_ok("jl_fetch");
    decode("jl_dec", 'h6F, 0);
    cyc("jl_jal", 0, 'h6F, 1, 0,  JL, 0, 0, 1, 2, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    aluwb("jl_wb");
    fetch_ok("lu_fetch");
    decode("lu_dec", 'h37, 0);
    cyc("lu_lui", 0, 'h37, 1, 0,  LU, 0, 0, 3, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    aluwb("lu_wb");
    fetch_ok("au_fetch");
    decode("au_dec", 'h17, 0);
    cyc("au_auipc", 0, 'h17, 1, 0,  AU, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    aluwb("au_wb");
    fetch_ok("ii_fetch");
    decode("ii_dec", 'h13, 0);
    cyc("ii_exec", 0, 'h13, 1, 0,  EI, 0, 0, 2, 1, 0, 2,  0, 0, 0, 0, 0, 0, 0);
    aluwb("ii_wb");

    // Reset in the middle of a stalled load returns to FETCH
    fetch_ok("rl_fetch");
    decode("rl_dec", 'h03, 0);
    cyc("rl_adr", 0, 'h03, 1, 0,  MA,  0, 0, 2, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    cyc("rl_rd",  0, 'h03, 0, 0,  MRD, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    cyc("rl_rst", 1, 'h03, 0, 0,  0, 0,0,0,0,0,0, 0,0,0,0,0,0,0);
    cyc("rl_rel", 0, 0, 0, 0,  F, 1, 0, 0, 2, 2, 0,  0, 0, 0, 0, 0, 0, 0);

    // Stall limit: rl_rel was stall cycle 1; 14 more stalled FETCH cycles, then FAULT
    for (int i = 2; i <= 15; i++)
      cyc($sformatf("stall%0d", i), 0, 0, 0, 0,  F, 1, 0, 0, 2, 2, 0,  0, 0, 0, 0, 0, 0, 0);
    cyc("fault0", 0, 0, 1, 1,  FL, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1);
    cyc("fault1", 0, 0, 1, 1,  FL, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1);
    cyc("flt_rst", 1, 0, 1, 0,  0, 0,0,0,0,0,0, 0,0,0,0,0,0,0);
    cyc("flt_rel", 0, 0, 1, 0,  F, 1, 0, 0, 2, 2, 0,  1, 1, 0, 0, 0, 0, 0);
    decode("flt_dec", 'h33, 0);

    // Let the monitor drain, bounded
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have parameter STALL_LIMIT, default 15: max consecutive mem_ready=0 cycles per memory state; 0 disables the limit.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port opcode  in  opcode_t (7)  instr[6:0] from the decoder, sampled in DECODE.
REQ-005 SHALL have port branch_taken  in  1  branch condition, valid in BRANCH.
REQ-006 SHALL have port mem_ready  in  1  memory completes the current access this cycle.
REQ-007 SHALL have port mem_req  out  1  memory access request.
REQ-008 SHALL have ports pc_write, ir_write, reg_write, mem_write  out  1 each  write strobes.
REQ-009 SHALL have port adr_src  out  1  memory address select: 0=PC, 1=ALUOut.
REQ-010 SHALL have ports alu_src_a  out  2 (00=PC, 01=old_pc, 10=rs1, 11=zero) and alu_src_b  out  2 (00=rs2, 01=imm_ext, 10=const 4).
REQ-011 SHALL have port result_src  out  2  00=ALUOut, 01=data register, 10=ALU result.
REQ-012 SHALL have port alu_op  out  alu_op_t  drives ALUdecoder.
REQ-013 SHALL have ports instr_retired, illegal_instr, mem_fault  out  1 each, plus state_dbg  out  4  current state.

Function
REQ-014 SHALL implement a Moore FSM; strobes gated only by mem_ready/branch_taken as stated below; unlisted outputs are 0, alu_op=ALU_OP__ADD.
REQ-015 FETCH SHALL drive mem_req=1, adr_src=0, a=00, b=10, result_src=10; on mem_ready: ir_write=1, pc_write=1, go DECODE; otherwise hold.
REQ-016 DECODE SHALL drive a=01, b=01 (target into ALUOut); next state by opcode: IType_load/SType->MEMADR, RType->EXECUTER, IType_logic->EXECUTEI, BType->BRANCH, JType->JAL, IType_jalr->JALR, UType_lui->LUI, UType_auipc->AUIPC, other->FETCH with illegal_instr=1 for one cycle.
REQ-017 MEMADR SHALL drive a=10, b=01; go MEMREAD if load, else MEMWRITE.
REQ-018 MEMREAD SHALL drive mem_req=1, adr_src=1; on mem_ready go MEMWB. MEMWB SHALL drive result_src=01, reg_write=1, go FETCH.
REQ-019 MEMWRITE SHALL drive mem_req=1, adr_src=1, mem_write=1; on mem_ready go FETCH.
REQ-020 EXECUTER SHALL drive a=10, b=00, alu_op=ALU_OP__REGISTER_OPERATION; EXECUTEI a=10, b=01, same alu_op; both go ALUWB.
REQ-021 ALUWB SHALL drive result_src=00, reg_write=1, go FETCH.
REQ-022 BRANCH SHALL drive a=10, b=00, alu_op=ALU_OP__BRANCH, result_src=00, pc_write=branch_taken; go FETCH.
REQ-023 JAL SHALL drive a=01, b=10, result_src=00, pc_write=1; go ALUWB.
REQ-024 JALR SHALL drive a=10, b=01, result_src=10, pc_write=1; go LINK. LINK SHALL drive a=01, b=10, result_src=10, reg_write=1; go FETCH.
REQ-025 LUI SHALL drive a=11, b=01; AUIPC a=01, b=01; both go ALUWB.
REQ-026 instr_retired SHALL pulse 1 for exactly one cycle in each state that returns to FETCH on that edge (MEMWB, MEMWRITE on mem_ready, ALUWB, BRANCH, LINK).
REQ-027 Stall counter SHALL clear on entry to FETCH/MEMREAD/MEMWRITE and increment each cycle there with mem_ready=0; when count reaches STALL_LIMIT (nonzero) with mem_ready=0, go FAULT.
REQ-028 FAULT SHALL drive mem_fault=1, all strobes and mem_req 0, and hold until reset.
REQ-029 mem_ready outside memory states SHALL be ignored.

Reset
REQ-030 While reset=1 at a rising edge, state SHALL become FETCH and stall counter 0; regardless of state, including mid-access or FAULT.
REQ-031 While reset is high, all outputs SHALL be 0; first cycle after release SHALL show state FETCH, mem_req=1.

Verification
REQ-032 RType, mem_ready always 1 -> FETCH,DECODE,EXECUTER,ALUWB; reg_write=1 in cycle 4; instr_retired once.
REQ-033 Load, mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, adr_src=1 throughout, MEMWB follows with result_src=01.
REQ-034 BType with branch_taken=0 then 1 -> pc_write 0 then 1 in BRANCH; 3 cycles per instruction.
REQ-035 JALR -> JALR pc_write=1 result_src=10, LINK reg_write=1 a=01 b=10, then FETCH.
REQ-036 Opcode 0x7F -> illegal_instr one cycle in DECODE, no reg/mem write, FETCH next.
REQ-037 STALL_LIMIT=15, mem_ready=0 in FETCH -> FAULT after 15 cycles, mem_fault=1; reset -> FETCH, mem_fault=0.
